// File: rtl/rkey_reverse_buf.sv
// Roundkey store for AES-128 decryption: captures the forward key-expander burst
// and serves keys in reverse round order with a registered, 1-cycle-latency read.
module rkey_reverse_buf #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [0:KW-1] rkey,
  input  logic          rkey_vld,
  input  logic          rkey_last,
  input  logic          rd_en,
  input  logic [3:0]    rd_round,
  output logic [0:KW-1] dkey,
  output logic          dkey_vld,
  output logic          key_ready,
  output logic          load_err
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    READY
  } state_t;

  state_t        state;
  logic [3:0]    wr_ptr;
  logic [0:KW-1] mem [0:NR];
  logic          rd_ok;
  logic [3:0]    rd_idx;

  // Reads use the registered key_ready, so a read issued alongside the first key of a
  // new burst still sees the old schedule (mem is sampled before the write lands).
  assign rd_ok  = key_ready && rd_en && (rd_round <= LAST_IDX);
  assign rd_idx = LAST_IDX - rd_round;

  // wr_ptr is parked at 0 in EMPTY and READY, so key 0 of any burst lands in mem[0].
  always_ff @(posedge clk) begin
    if (rkey_vld) begin
      mem[wr_ptr] <= rkey;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      wr_ptr    <= 4'd0;
      key_ready <= 1'b0;
      load_err  <= 1'b0;
      dkey      <= '0;
      dkey_vld  <= 1'b0;
    end else begin
      dkey_vld <= rd_ok;
      if (rd_ok) begin
        dkey <= mem[rd_idx];
      end

      case (state)
        EMPTY: begin
          if (rkey_vld) begin
            wr_ptr <= 4'd1;
            state  <= LOADING;
          end
        end

        LOADING: begin
          if (rkey_vld) begin
            if (rkey_last && (wr_ptr == LAST_IDX)) begin
              wr_ptr    <= 4'd0;
              key_ready <= 1'b1;
              load_err  <= 1'b0;
              state     <= READY;
            end else if (rkey_last || (wr_ptr == LAST_IDX)) begin
              // Burst ended early or ran past NR keys: drop it and wait for a fresh one.
              wr_ptr   <= 4'd0;
              load_err <= 1'b1;
              state    <= EMPTY;
            end else begin
              wr_ptr <= wr_ptr + 4'd1;
            end
          end
        end

        READY: begin
          if (rkey_vld) begin
            key_ready <= 1'b0;
            wr_ptr    <= 4'd1;
            state     <= LOADING;
          end
        end

        default: begin
          wr_ptr    <= 4'd0;
          key_ready <= 1'b0;
          state     <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rkey_reverse_buf.sv
// Scoreboard bench for rkey_reverse_buf: a queue/array reference model predicts
// each read and the status flags; a negedge monitor retires every dkey_vld beat.
module tb_rkey_reverse_buf;

  localparam int NR = 10;
  localparam int KW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [0:KW-1] rkey;
  logic          rkey_vld;
  logic          rkey_last;
  logic          rd_en;
  logic [3:0]    rd_round;
  logic [0:KW-1] dkey;
  logic          dkey_vld;
  logic          key_ready;
  logic          load_err;

  always #5 clk = ~clk;

  rkey_reverse_buf #(.NR(NR), .KW(KW)) dut (
    .clk      (clk),
    .rst      (rst),
    .rkey     (rkey),
    .rkey_vld (rkey_vld),
    .rkey_last(rkey_last),
    .rd_en    (rd_en),
    .rd_round (rd_round),
    .dkey     (dkey),
    .dkey_vld (dkey_vld),
    .key_ready(key_ready),
    .load_err (load_err)
  );

  int total = 0;
  int bad   = 0;

  logic [0:KW-1] exp_q[$];

  // Reference model: the burst is a growing list that is committed as a whole schedule.
  logic [0:KW-1] m_sched [0:NR];
  logic [0:KW-1] m_burst[$];
  bit            m_inburst, m_ready, m_err, m_vld;
  logic [0:KW-1] m_dkey;

  logic [0:KW-1] c1_keys [0:NR];
  logic [0:KW-1] a1_keys [0:NR];
  logic [0:KW-1] bk [0:15];

  task automatic checkVal(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [0:KW-1] randKey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void modelStep(bit r, bit v, bit l, logic [0:KW-1] k, bit rd, logic [3:0] rr);
    int n;
    if (r) begin
      m_ready = 0; m_err = 0; m_inburst = 0; m_vld = 0; m_dkey = '0;
      m_burst.delete();
      return;
    end
    m_vld = 0;
    if (m_ready && rd && (int'(rr) <= NR)) begin
      m_dkey = m_sched[NR - int'(rr)];
      m_vld  = 1;
      exp_q.push_back(m_dkey);
    end
    if (v) begin
      if (!m_inburst) begin
        m_burst.delete();
        m_burst.push_back(k);
        m_inburst = 1;
        m_ready   = 0;
      end else begin
        n = m_burst.size();
        m_burst.push_back(k);
        if (l && n == NR) begin
          for (int i = 0; i <= NR; i++) m_sched[i] = m_burst[i];
          m_ready = 1; m_err = 0; m_inburst = 0;
        end else if (l || n == NR) begin
          m_err = 1; m_inburst = 0;
        end
      end
    end
  endfunction

  task automatic checkOutput();
    checkVal("key_ready", {127'd0, key_ready}, {127'd0, m_ready});
    checkVal("load_err",  {127'd0, load_err},  {127'd0, m_err});
    checkVal("dkey_vld",  {127'd0, dkey_vld},  {127'd0, m_vld});
    checkVal("dkey_hold", dkey, m_dkey);
  endtask

  task automatic applyStimulus(input bit r, input bit v, input bit l, input logic [0:KW-1] k,
                               input bit rd, input logic [3:0] rr);
    rst = r; rkey_vld = v; rkey_last = l; rkey = k; rd_en = rd; rd_round = rr;
    @(posedge clk);
    modelStep(r, v, l, k, rd, rr);
    #1;
    checkOutput();
  endtask

  task automatic readKey(input logic [3:0] rr);
    applyStimulus(0, 0, 0, randKey(), 1, rr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, randKey(), 0, 4'd0);
  endtask

  // One key per cycle from bk[]; optional gap after key gap_after, optional random reads.
  task automatic sendBurst(input int n, input int last_idx, input int gap_after, input int gap_len,
                           input bit rnd_rd, input int first_rd);
    bit rd;
    logic [3:0] rr;
    for (int i = 0; i < n; i++) begin
      rd = rnd_rd ? 1'($urandom_range(0, 1)) : 1'b0;
      rr = 4'($urandom_range(0, 15));
      if (i == 0 && first_rd >= 0) begin
        rd = 1; rr = 4'(first_rd);
      end
      applyStimulus(0, 1, (i == last_idx), bk[i], rd, rr);
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++)
          applyStimulus(0, 0, 0, randKey(), rnd_rd ? 1'($urandom_range(0, 1)) : 1'b0,
                        4'($urandom_range(0, 15)));
      end
    end
  endtask

  always @(negedge clk) begin
    logic [0:KW-1] e;
    if (dkey_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL spurious_read: got dkey %h with dkey_vld=1, required no read", dkey);
      end else begin
        e = exp_q.pop_front();
        checkVal("read_data", dkey, e);
      end
    end
  end

  initial begin
    c1_keys[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    c1_keys[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    c1_keys[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    c1_keys[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    c1_keys[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    c1_keys[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    c1_keys[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    c1_keys[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    c1_keys[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    c1_keys[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    c1_keys[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    a1_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    a1_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    a1_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    a1_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    a1_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    a1_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    a1_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    a1_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    a1_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    a1_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    a1_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1; rkey_vld = 0; rkey_last = 0; rkey = '0; rd_en = 0; rd_round = '0;
    applyStimulus(1, 0, 0, '0, 0, 4'd0);
    applyStimulus(1, 0, 0, '0, 1, 4'd0);
    readKey(4'd0);

    $display("[TB] FIPS-197 C.1 schedule, single read then reverse sweep");
    for (int i = 0; i <= NR; i++) bk[i] = c1_keys[i];
    sendBurst(11, 10, -1, 0, 0, -1);
    readKey(4'd0);
    idle(1);
    for (int r = 10; r >= 0; r--) readKey(4'(r));
    for (int r = 11; r <= 15; r++) readKey(4'(r));
    idle(1);

    $display("[TB] burst with a gap after key 4");
    for (int i = 0; i <= NR; i++) bk[i] = randKey();
    sendBurst(11, 10, 4, 3, 0, -1);
    readKey(4'd6);
    readKey(4'd10);

    $display("[TB] short burst ending at key 7, then a good burst");
    for (int i = 0; i <= NR; i++) bk[i] = randKey();
    sendBurst(8, 7, -1, 0, 0, -1);
    readKey(4'd0);
    for (int i = 0; i <= NR; i++) bk[i] = c1_keys[i];
    sendBurst(11, 10, -1, 0, 0, -1);
    readKey(4'd0);

    $display("[TB] overlong burst without last marker");
    for (int i = 0; i < 12; i++) bk[i] = randKey();
    sendBurst(12, -1, -1, 0, 1, -1);
    idle(2);
    for (int i = 0; i <= NR; i++) bk[i] = c1_keys[i];
    sendBurst(11, 10, -1, 0, 0, -1);

    $display("[TB] new burst overlapping a read in READY");
    for (int i = 0; i <= NR; i++) bk[i] = a1_keys[i];
    sendBurst(11, 10, -1, 0, 1, 0);
    readKey(4'd0);
    readKey(4'd10);

    $display("[TB] reset mid-burst");
    for (int i = 0; i <= NR; i++) bk[i] = randKey();
    sendBurst(6, -1, -1, 0, 0, -1);
    applyStimulus(1, 0, 0, randKey(), 1, 4'd0);
    readKey(4'd0);
    readKey(4'd3);
    sendBurst(11, 10, -1, 0, 1, -1);
    readKey(4'd0);

    $display("[TB] randomized bursts and reads");
    for (int it = 0; it < 40; it++) begin
      int kind, n;
      for (int i = 0; i < 16; i++) bk[i] = randKey();
      kind = $urandom_range(0, 3);
      if (kind <= 1) sendBurst(11, 10, $urandom_range(0, 10), $urandom_range(0, 3), 1, -1);
      else if (kind == 2) begin
        n = $urandom_range(1, 10);
        sendBurst(n, n - 1, -1, 0, 1, -1);
      end else sendBurst(12, -1, -1, 0, 1, -1);
      for (int j = 0; j < 6; j++) readKey(4'($urandom_range(0, 12)));
    end

    idle(2);
    checkVal("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
